ahb_lite_sram_slave: RTL

//  AHB-Lite responder: the slave end of the per-master HREADY switch. Serves one

---
 rtl/ahb_lite_sram_slave_pkg.sv | 28 ++
 rtl/ahb_lite_sram_slave_mem.sv | 38 +++
 rtl/ahb_lite_sram_slave.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite encodings for the SRAM responder, plus the byte-lane enable helper.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } HTRANS_state;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Little-endian lane enables; size is only ever byte/half/word once accepted.
    function automatic logic [3:0] byte_en(input logic [1:0] lane, input logic [1:0] size);
        if (size == HSIZE_BYTE[1:0])
            byte_en = 4'b0001 << lane;
        else if (size == HSIZE_HALF[1:0])
            byte_en = lane[1] ? 4'b1100 : 4'b0011;
        else
            byte_en = 4'b1111;
    endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_mem.sv
// Word-wide SRAM with per-byte write enables and a registered read port.
module ahb_sram_byte_mem #(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [3:0]       i_be,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [31:0]      i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_ridx,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] r_rdata;

    // Array has no reset so contents survive a bus reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_ridx];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: wait-state insertion, two-cycle ERROR, completion pulse
// for the HREADY switch, and write-to-read forwarding on the same word.
//
//  state  | meaning
//  S_IDLE | no data phase pending, zero-wait OKAY
//  S_DATA | OKAY data phase, counting down wait cycles
//  S_ERR1 | first ERROR cycle (HREADYOUT low)
//  S_ERR2 | second ERROR cycle (HREADYOUT high), may accept next transfer
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  HTRANS_state           HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  slave_done
);

    localparam int                  IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0] SPAN  = (ADDR_WIDTH+1)'(4 * MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t           r_state;
    logic [3:0]       r_wait_cnt;
    logic             r_write;
    logic [1:0]       r_lane;
    logic [1:0]       r_size;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_fwd_be;
    logic [31:0]      r_fwd_data;

    logic [ADDR_WIDTH-1:0] w_offset;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_ready;
    logic                  w_complete;
    logic                  w_accept;
    logic                  w_err;
    logic                  w_commit;
    logic                  w_rd_issue;
    logic [3:0]            w_be;
    logic [31:0]           w_mem_rdata;

    assign w_offset   = HADDR - BASE_ADDR;
    assign w_idx      = w_offset[IDX_W+1:2];
    assign w_ready    = (r_state == S_DATA) ? (r_wait_cnt == 4'd0) : (r_state != S_ERR1);
    assign w_complete = ((r_state == S_DATA) && (r_wait_cnt == 4'd0)) || (r_state == S_ERR2);
    assign w_accept   = HSEL && HREADY && w_ready && ((HTRANS == NONSEQ) || (HTRANS == SEQ));
    assign w_err      = (HADDR < BASE_ADDR) || ({1'b0, w_offset} >= SPAN)
                      || (HSIZE > HSIZE_WORD)
                      || ((HSIZE == HSIZE_HALF) && w_offset[0])
                      || ((HSIZE == HSIZE_WORD) && (w_offset[1:0] != 2'b00));
    assign w_commit   = HRESETn && (r_state == S_DATA) && (r_wait_cnt == 4'd0) && r_write;
    assign w_rd_issue = HRESETn && w_accept && !w_err && !HWRITE;
    assign w_be       = byte_en(r_lane, r_size);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_write    <= 1'b0;
            r_lane     <= '0;
            r_size     <= '0;
            r_idx      <= '0;
            r_fwd_be   <= '0;
            r_fwd_data <= '0;
        end else begin
            if (w_accept) begin
                r_write    <= HWRITE;
                r_lane     <= w_offset[1:0];
                r_size     <= HSIZE[1:0];
                r_idx      <= w_idx;
                r_state    <= w_err ? S_ERR1 : S_DATA;
                r_wait_cnt <= w_err ? 4'd0 : 4'(WAIT_STATES);
            end else begin
                case (r_state)
                    S_DATA:  if (r_wait_cnt != 4'd0) r_wait_cnt <= r_wait_cnt - 4'd1;
                             else r_state <= S_IDLE;
                    S_ERR1:  r_state <= S_ERR2;
                    S_ERR2:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
            // SRAM returns pre-write data when commit and read hit one word on one edge.
            if (w_rd_issue) begin
                r_fwd_be   <= (w_commit && (r_idx == w_idx)) ? w_be : 4'b0000;
                r_fwd_data <= HWDATA;
            end
        end
    end

    ahb_sram_byte_mem #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mem (
        .i_clk   (HCLK),
        .i_rst_n (HRESETn),
        .i_we    (w_commit),
        .i_be    (w_be),
        .i_widx  (r_idx),
        .i_wdata (HWDATA),
        .i_re    (w_rd_issue),
        .i_ridx  (w_idx),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        HRDATA = w_mem_rdata;
        for (int b = 0; b < 4; b++) begin
            if (r_fwd_be[b]) HRDATA[8*b +: 8] = r_fwd_data[8*b +: 8];
        end
    end

    assign HREADYOUT  = w_ready;
    assign HRESP      = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign slave_done = w_complete && !(w_accept && (HTRANS == SEQ));

endmodule
